// File: rtl/fm_cmd_seq.sv
// fm_cmd_seq: timed command sequencer for the fmsynth register bus.
// The CPU queues register writes and sample-accurate delays without stalling;
// the sequencer replays them to fmsynth, honouring its bus_wait handshake.
//
// Handshakes:
//   push side : a command is transferred on the rising clk edge where
//               push_valid && push_ready. push_ready is low while the queue is
//               full or while flush is asserted, so a push in a flush cycle is dropped.
//   fm side   : fm_wren qualifies fm_addr/fm_wrdata; a write is committed on
//               the rising edge where fm_wren && !fm_wait, and the sequencer
//               holds all three outputs stable until then.
module fm_cmd_seq #(
  parameter int DEPTH_LOG2 = 4,
  parameter int SAMPLE_DIV = 506
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic                  push_delay,
  input  logic [7:0]            push_addr,
  input  logic [31:0]           push_data,
  input  logic                  flush,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  busy,
  output logic [7:0]            fm_addr,
  output logic [31:0]           fm_wrdata,
  output logic                  fm_wren,
  input  logic                  fm_wait,
  output logic [1:0]            dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [DEPTH_LOG2:0]   LVL_ONE   = 1;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL  = DEPTH;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
  localparam logic [TW-1:0]         TICK_ONE  = 1;
  localparam logic [TW-1:0]         TICK_LAST = TW'(SAMPLE_DIV - 1);

  // One queued command: delay flag, register address, write data / tick count.
  typedef struct packed {
    logic        is_delay;
    logic [7:0]  addr;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DELAY = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Sample tick
  // ---------------------------------------------------------------------------
  logic [TW-1:0] tick_cnt_q;
  logic          tick;

  assign tick = (tick_cnt_q == TICK_LAST);

  // Free-running sample-period counter; flush deliberately leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TICK_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  entry_t                  mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q;
  logic [DEPTH_LOG2:0]     level_q;
  logic                    full;
  logic                    empty;
  logic                    push_fire;
  logic                    pop_fire;
  entry_t                  head;
  entry_t                  push_entry;
  state_t                  state_q;

  assign full       = (level_q == LVL_FULL);
  assign empty      = (level_q == '0);
  assign push_ready = !full && !flush;
  assign push_fire  = push_valid && push_ready;
  // The head is consumed only from idle, and never in a flush cycle.
  assign pop_fire   = (state_q == S_IDLE) && !empty && !flush;
  assign head       = mem_q[rd_ptr_q];

  assign push_entry.is_delay = push_delay;
  assign push_entry.addr     = push_addr;
  assign push_entry.data     = push_data;

  // Storage array: written on accepted pushes, no reset needed.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // Pointers and occupancy; flush empties the queue in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_fire) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push_fire, pop_fire})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Replay FSM
  // ---------------------------------------------------------------------------
  logic [7:0]  fm_addr_q;
  logic [31:0] fm_wrdata_q;
  logic        fm_wren_q;
  logic [15:0] dcnt_q;

  // Replay sequencer: issues writes, waits out fm_wait, counts delay ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      fm_addr_q   <= '0;
      fm_wrdata_q <= '0;
      fm_wren_q   <= 1'b0;
      dcnt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop_fire) begin
            if (head.is_delay) begin
              // A zero-length delay is consumed without waiting for a tick.
              if (head.data[15:0] != 16'd0) begin
                dcnt_q  <= head.data[15:0];
                state_q <= S_DELAY;
              end
            end else begin
              fm_addr_q   <= head.addr;
              fm_wrdata_q <= head.data;
              fm_wren_q   <= 1'b1;
              state_q     <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          // A write in flight is never abandoned, not even by flush.
          if (!fm_wait) begin
            fm_wren_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_DELAY: begin
          if (flush) begin
            dcnt_q  <= '0;
            state_q <= S_IDLE;
          end else if (tick) begin
            dcnt_q <= dcnt_q - 16'd1;
            if (dcnt_q == 16'd1) begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign fm_addr   = fm_addr_q;
  assign fm_wrdata = fm_wrdata_q;
  assign fm_wren   = fm_wren_q;
  assign level     = level_q;
  assign busy      = !empty || (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fm_cmd_seq.sv
// Directed testbench for fm_cmd_seq: single write, long fm_wait, delays,
// queue saturation, flush in delay and in write, and asynchronous reset.
module tb_fm_cmd_seq;

  localparam int DL2 = 4;
  localparam int SD  = 506;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push_valid = 1'b0;
  logic          push_ready;
  logic          push_delay = 1'b0;
  logic [7:0]    push_addr = '0;
  logic [31:0]   push_data = '0;
  logic          flush = 1'b0;
  logic [DL2:0]  level;
  logic          busy;
  logic [7:0]    fm_addr;
  logic [31:0]   fm_wrdata;
  logic          fm_wren;
  logic          fm_wait = 1'b0;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  fm_cmd_seq #(.DEPTH_LOG2(DL2), .SAMPLE_DIV(SD)) dut (
    .clk        (clk),
    .reset      (reset),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_delay (push_delay),
    .push_addr  (push_addr),
    .push_data  (push_data),
    .flush      (flush),
    .level      (level),
    .busy       (busy),
    .fm_addr    (fm_addr),
    .fm_wrdata  (fm_wrdata),
    .fm_wren    (fm_wren),
    .fm_wait    (fm_wait),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard: expected writes vs. writes committed on the fm bus
  // ---------------------------------------------------------------------------
  logic [39:0] exp_q[$];
  logic [39:0] act_q[$];
  int          act_cyc_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // A write commits on the next edge when wren is high and wait is low.
  always @(negedge clk) begin
    if (!reset && fm_wren && !fm_wait) begin
      act_q.push_back({fm_addr, fm_wrdata});
      act_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic d, input logic [7:0] a, input logic [31:0] dat);
    push_valid = 1'b1;
    push_delay = d;
    push_addr  = a;
    push_data  = dat;
    step();
    push_valid = 1'b0;
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [31:0] dat);
    exp_q.push_back({a, dat});
    push(1'b0, a, dat);
  endtask

  task automatic wait_acc(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (act_q.size() < n && k < budget) begin
      step();
      k++;
    end
    check(tag, act_q.size() >= n, 1'b1);
  endtask

  task automatic cmp(input string tag, output int cyc_o);
    logic [39:0] got;
    logic [39:0] want;
    cyc_o = -1;
    check({tag, "_avail"}, (act_q.size() != 0) && (exp_q.size() != 0), 1'b1);
    if (act_q.size() != 0 && exp_q.size() != 0) begin
      got   = act_q.pop_front();
      cyc_o = act_cyc_q.pop_front();
      want  = exp_q.pop_front();
      check(tag, got, want);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int ca, cb, cc, cd, stable;

    step(3);
    reset = 1'b0;
    step();
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_wren", fm_wren, 0);
    check("rst_addr", fm_addr, 0);
    check("rst_data", fm_wrdata, 0);
    check("rst_ready", push_ready, 1);
    check("rst_state", dbg_state, 0);

    // 1: single write with fm_wait low
    push_wr(8'h02, 32'h0000_0001);
    check("t1_level", level, 1);
    check("t1_busy_q", busy, 1);
    step();
    check("t1_wren_hi", fm_wren, 1);
    check("t1_addr", fm_addr, 8'h02);
    check("t1_data", fm_wrdata, 32'h1);
    check("t1_state_w", dbg_state, 1);
    check("t1_busy_w", busy, 1);
    step();
    check("t1_wren_lo", fm_wren, 0);
    check("t1_busy_lo", busy, 0);
    check("t1_addr_keep", fm_addr, 8'h02);
    check("t1_nacc", act_q.size(), 1);
    cmp("t1_write", ca);

    // 2: fm_wait held high for 300 cycles
    fm_wait = 1'b1;
    push_wr(8'h10, 32'hDEAD_BEEF);
    push_wr(8'h11, 32'h0000_0055);
    stable = 0;
    for (int i = 0; i < 300; i++) begin
      if (fm_wren === 1'b1 && fm_addr === 8'h10 && fm_wrdata === 32'hDEAD_BEEF) stable++;
      step();
    end
    check("t2_stable", stable, 300);
    check("t2_none_yet", act_q.size(), 0);
    check("t2_level", level, 1);
    fm_wait = 1'b0;
    step();
    check("t2_done_wren", fm_wren, 0);
    cmp("t2_first", ca);
    step();
    check("t2_next_wren", fm_wren, 1);
    check("t2_next_addr", fm_addr, 8'h11);
    step();
    cmp("t2_second", cb);
    check("t2_busy_lo", busy, 0);

    // 3: write A, delay 3, write B
    push_wr(8'h20, 32'h0000_000A);
    push(1'b1, 8'h00, 32'd3);
    push_wr(8'h21, 32'h0000_000B);
    wait_acc("t3_wait", 2, 2000);
    cmp("t3_a", ca);
    cmp("t3_b", cb);
    check("t3_gap_lo", (cb - ca) >= 2 * SD + 4, 1'b1);
    check("t3_gap_hi", (cb - ca) <= 3 * SD + 3, 1'b1);
    // delay 0 costs only the idle pop cycle
    push_wr(8'h22, 32'h0000_000C);
    push(1'b1, 8'h00, 32'd0);
    push_wr(8'h23, 32'h0000_000D);
    wait_acc("t3_wait0", 2, 50);
    cmp("t3_c", cc);
    cmp("t3_d", cd);
    check("t3_gap0", cd - cc, 3);

    // 4: saturate the queue with fm_wait high
    fm_wait = 1'b1;
    for (int i = 0; i < 17; i++) begin
      push_wr(8'h40 + 8'(i), 32'h1000_0000 + 32'(i));
    end
    check("t4_level", level, 16);
    check("t4_ready", push_ready, 0);
    check("t4_state", dbg_state, 1);
    check("t4_head_addr", fm_addr, 8'h40);
    push(1'b0, 8'hEE, 32'hFFFF_FFFF);
    check("t4_level_hold", level, 16);
    fm_wait = 1'b0;
    wait_acc("t4_drain", 17, 200);
    step(3);
    check("t4_count", act_q.size(), 17);
    for (int i = 0; i < 17; i++) begin
      cmp($sformatf("t4_order%0d", i), ca);
    end
    check("t4_level0", level, 0);
    check("t4_busy0", busy, 0);

    // 5a: flush during a long delay with 5 writes queued
    push(1'b1, 8'h00, 32'd100);
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 8'h70 + 8'(i), 32'(i));
    end
    step(10);
    check("t5_level", level, 5);
    check("t5_state_d", dbg_state, 2);
    flush = 1'b1;
    push_valid = 1'b1;
    push_delay = 1'b0;
    push_addr = 8'h77;
    push_data = 32'h77;
    #1;
    check("t5_ready_flush", push_ready, 0);
    step();
    flush = 1'b0;
    push_valid = 1'b0;
    check("t5_level0", level, 0);
    check("t5_state_i", dbg_state, 0);
    check("t5_busy0", busy, 0);
    step(300);
    check("t5_no_wren", act_q.size(), 0);
    check("t5_level_stay", level, 0);

    // 5b: flush while a write waits on fm_wait
    fm_wait = 1'b1;
    push_wr(8'h50, 32'h0000_0005);
    push(1'b0, 8'h51, 32'h0000_0006);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t5w_level0", level, 0);
    check("t5w_wren", fm_wren, 1);
    check("t5w_state", dbg_state, 1);
    check("t5w_addr", fm_addr, 8'h50);
    fm_wait = 1'b0;
    step();
    check("t5w_done", fm_wren, 0);
    cmp("t5w_write", ca);
    step(5);
    check("t5w_no_more", act_q.size(), 0);
    check("t5w_busy0", busy, 0);

    // 6: asynchronous reset while a write is stalled
    fm_wait = 1'b1;
    push(1'b0, 8'h60, 32'h0000_0060);
    push(1'b0, 8'h61, 32'h0000_0061);
    check("t6_pre_wren", fm_wren, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_wren0", fm_wren, 0);
    check("t6_level0", level, 0);
    check("t6_busy0", busy, 0);
    check("t6_state0", dbg_state, 0);
    step(2);
    reset = 1'b0;
    fm_wait = 1'b0;
    push_wr(8'h62, 32'h0000_0062);
    wait_acc("t6_resume", 1, 20);
    cmp("t6_write", ca);
    step();
    check("t6_busy_end", busy, 0);
    check("t6_leftover", act_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
